regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: register count, a power of 2 and at least 2; AW = clog2(DEPTH).
REQ-003 SHALL have parameter NRD, default 2: number of read ports, 1..4.
REQ-004 SHALL have parameter SYNC_RD, default 0: 0 gives combinational read, 1 gives registered read with 1-cycle latency.
REQ-005 SHALL have parameter BYPASS, default 1: 1 forwards the same-cycle write data to matching read ports.
REQ-006 SHALL have parameter ZERO_REG, default 0: 1 makes R0 read as zero, ignores writes to it and never marks it busy.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port wen, input, 1 bit: write enable.
REQ-010 SHALL have port waddr, input, AW bits: write address.
REQ-011 SHALL have port wdata, input, DATA_W bits: write data.
REQ-012 SHALL have port raddr, input, NRD*AW bits: read addresses, port k at bits [k*AW +: AW].
REQ-013 SHALL have port rdata, output, NRD*DATA_W bits: read data, port k at bits [k*DATA_W +: DATA_W].
REQ-014 SHALL have port rbusy, output, NRD bits: per read port, the scoreboard busy bit of the register addressed by raddr, with the same latency as rdata.
REQ-015 SHALL have port rsv_en, input, 1 bit: request to reserve (mark pending) the register at rsv_addr.
REQ-016 SHALL have port rsv_addr, input, AW bits: address to reserve.
REQ-017 SHALL have port rsv_conflict, output, 1 bit: combinational; high when rsv_en=1 and busy[rsv_addr]=1.
REQ-018 SHALL have port busy_cnt, output, AW+1 bits: registered count of busy registers.

Function
REQ-019 SHALL write wdata into reg[waddr] at the rising edge when wen=1, except when ZERO_REG=1 and waddr=0.
REQ-020 SHALL, with SYNC_RD=0, drive rdata[k] combinationally from reg[raddr[k]].
REQ-021 SHALL, with SYNC_RD=1, register rdata[k] and rbusy[k] at each rising edge from the values present before that edge, including any bypass; the output is valid the cycle after raddr is applied.
REQ-022 SHALL, with BYPASS=1 and wen=1 and raddr[k]=waddr (and not the ignored R0), present wdata on rdata[k] instead of the stored value.
REQ-023 SHALL, with BYPASS=0, present the old stored value on a same-cycle read/write collision.
REQ-024 SHALL, with ZERO_REG=1, return 0 on any read of R0 and return rbusy=0 for R0.
REQ-025 SHALL set busy[rsv_addr] at the edge when rsv_en=1 and rsv_conflict=0; a reservation of R0 with ZERO_REG=1 SHALL be ignored.
REQ-026 SHALL clear busy[waddr] at the edge when wen=1.
REQ-027 SHALL, when wen=1 and rsv_en=1 target the same address in one cycle, let the set win: busy stays 1 and busy_cnt is unchanged.
REQ-028 SHALL update busy_cnt incrementally: +1 on a 0->1 busy transition, -1 on a 1->0 transition, and a net 0 when both occur on different registers in the same cycle.
REQ-029 SHALL leave a write to a non-busy register with busy and busy_cnt unchanged.
REQ-030 SHALL leave busy unchanged on a conflicting reservation (rsv_conflict=1), with no state change.
REQ-031 SHALL keep busy_cnt within 0..DEPTH and never wrap.

Reset
REQ-032 SHALL, when rst=1 at a rising edge, clear all registers, all busy bits, busy_cnt and (with SYNC_RD=1) the registered rdata/rbusy to 0.
REQ-033 SHALL give rst priority over wen and rsv_en in the same cycle.
REQ-034 SHALL have no asynchronous reset path.

Structure
REQ-035 SHALL take the port-lane index helpers and the DEPTH/NRD legality checks from the shared package rf_pkg.
REQ-036 SHALL implement the busy-bit vector and busy_cnt in one sub-module, regfile_scoreboard; storage and read muxing SHALL stay in regfile_sb.

Verification
REQ-037 SHALL be verified: rst=1 for one edge, then read all 16 registers -> every rdata=0, rbusy=0, busy_cnt=0.
REQ-038 SHALL be verified: write R5=0xDEADBEEF while raddr0=5, BYPASS=1, SYNC_RD=0 -> rdata0=0xDEADBEEF in the same cycle; with BYPASS=0 -> old value 0, then 0xDEADBEEF the next cycle.
REQ-039 SHALL be verified: ZERO_REG=1, write R0=0x1234, rsv R0 -> R0 reads 0, busy_cnt=0.
REQ-040 SHALL be verified: rsv R3, then rsv R3 again -> rsv_conflict=1 on the second request, busy_cnt=1; then wen R3 -> busy_cnt=0, rbusy for R3=0.
REQ-041 SHALL be verified: in one cycle, wen R3 (busy) and rsv R3 -> busy stays 1, busy_cnt stays 1; in one cycle, wen R3 and rsv R7 -> busy_cnt unchanged, R7 busy.
REQ-042 SHALL be verified: SYNC_RD=1, apply raddr1=9 after R9=0xA5A5A5A5 -> rdata1 updates exactly one cycle later; assert rst mid-sequence with wen=1 -> all state returns to 0.

Source files
------------

// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rf_pkg
//  Purpose  : Shared helpers for the register file: packed-port lane offsets
//             and elaboration-time legality checks for DEPTH and NRD.
//  Revision : 1.0 - initial release
// ============================================================================
package rf_pkg;

    // Lowest bit of lane k in a packed bus whose lanes are w bits wide.
    function automatic int unsigned lane_lo(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

    // DEPTH must be a power of two and at least 2.
    function automatic bit depth_ok(input int unsigned d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

    // Between one and four read ports are supported.
    function automatic bit nrd_ok(input int unsigned n);
        return (n >= 1) && (n <= 4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_scoreboard
//  Purpose  : Per-register busy bits plus an incrementally maintained count
//             of busy registers. Reservations set a bit, writes clear it.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
    parameter  int DEPTH    = 16,
    parameter  int ZERO_REG = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    output logic [DEPTH-1:0] busy,
    output logic             rsv_conflict,
    output logic [AW:0]      busy_cnt
);

    localparam logic [AW-1:0] c_zero_addr = '0;
    localparam logic [AW:0]   c_full      = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_one       = (AW+1)'(1);

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [DEPTH-1:0] set_vec, clr_vec;
    logic [AW:0]      busy_cnt_q, busy_cnt_d;
    logic             same_addr, rsv_r0, inc, dec;

    // Next busy vector and count; a same-address write+reserve leaves the bit set.
    always_comb begin
        rsv_conflict = rsv_en && busy_q[rsv_addr];
        same_addr    = wen && (waddr == rsv_addr);
        rsv_r0       = (ZERO_REG != 0) && (rsv_addr == c_zero_addr);
        set_vec      = '0;
        clr_vec      = '0;
        if (rsv_en && !rsv_r0 && (!busy_q[rsv_addr] || same_addr)) begin
            set_vec[rsv_addr] = 1'b1;
        end
        if (wen) begin
            clr_vec[waddr] = 1'b1;
        end
        busy_d = (busy_q & ~clr_vec) | set_vec;
        inc    = |(set_vec & ~busy_q);
        dec    = |(clr_vec & busy_q & ~set_vec);
        busy_cnt_d = busy_cnt_q;
        if (inc && !dec && (busy_cnt_q != c_full)) begin
            busy_cnt_d = busy_cnt_q + c_one;
        end else if (dec && !inc && (busy_cnt_q != '0)) begin
            busy_cnt_d = busy_cnt_q - c_one;
        end
    end

    // Scoreboard state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = busy_cnt_q;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sb
//  Purpose  : Multi-read-port register file with optional write bypass,
//             optional registered reads, optional hard-wired zero R0, and a
//             busy scoreboard for pending results.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sb
    import rf_pkg::*;
#(
    parameter  int DATA_W   = 32,
    parameter  int DEPTH    = 16,
    parameter  int NRD      = 2,
    parameter  int SYNC_RD  = 0,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_addr,
    output logic                  rsv_conflict,
    output logic [AW:0]           busy_cnt
);

    localparam logic [AW-1:0] c_zero_addr = '0;

    // Reject illegal configurations at elaboration.
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("regfile_sb: DEPTH must be a power of 2 and at least 2");
    end
    if (!nrd_ok(NRD)) begin : g_bad_nrd
        $error("regfile_sb: NRD must be in 1..4");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              wr_ok;
    logic [DEPTH-1:0]  busy;

    // Writes to R0 are dropped when it is hard-wired to zero.
    always_comb begin
        wr_ok = wen && !((ZERO_REG != 0) && (waddr == c_zero_addr));
        mem_d = mem_q;
        if (wr_ok) begin
            mem_d[waddr] = wdata;
        end
    end

    // Register storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .wen          (wen),
        .waddr        (waddr),
        .rsv_en       (rsv_en),
        .rsv_addr     (rsv_addr),
        .busy         (busy),
        .rsv_conflict (rsv_conflict),
        .busy_cnt     (busy_cnt)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]     ra;
        logic              is_r0;
        logic [DATA_W-1:0] rdata_d;
        logic              rbusy_d;

        // Read mux with optional forwarding of this cycle's write data.
        always_comb begin
            ra      = raddr[lane_lo(k, AW) +: AW];
            is_r0   = (ZERO_REG != 0) && (ra == c_zero_addr);
            rdata_d = mem_q[ra];
            if ((BYPASS != 0) && wr_ok && (ra == waddr)) begin
                rdata_d = wdata;
            end
            if (is_r0) begin
                rdata_d = '0;
            end
            rbusy_d = busy[ra] && !is_r0;
        end

        if (SYNC_RD != 0) begin : g_sync
            logic [DATA_W-1:0] rdata_q;
            logic              rbusy_q;

            // One-cycle read pipeline stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_q <= '0;
                    rbusy_q <= 1'b0;
                end else begin
                    rdata_q <= rdata_d;
                    rbusy_q <= rbusy_d;
                end
            end

            assign rdata[lane_lo(k, DATA_W) +: DATA_W] = rdata_q;
            assign rbusy[k]                            = rbusy_q;
        end else begin : g_comb
            assign rdata[lane_lo(k, DATA_W) +: DATA_W] = rdata_d;
            assign rbusy[k]                            = rbusy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_sb
//  Purpose  : Self-checking bench for regfile_sb. Three configurations share
//             one stimulus stream: A = comb read + bypass, B = no bypass with
//             zero R0, C = registered read + bypass.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic        wen;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [7:0]  raddr;
    logic        rsv_en;
    logic [3:0]  rsv_addr;

    logic [63:0] o_rdata [3];
    logic [1:0]  o_rbusy [3];
    logic        o_conf  [3];
    logic [4:0]  o_cnt   [3];

    int total = 0;
    int bad   = 0;

    // Configuration table per instance.
    int cfg_byp  [3] = '{1, 0, 1};
    int cfg_zr   [3] = '{0, 1, 0};
    int cfg_sync [3] = '{0, 0, 1};

    // Reference model state.
    logic [31:0] m_mem  [3][16];
    bit          m_busy [3][16];
    logic [31:0] m_rq   [3][2];
    bit          m_rqb  [3][2];

    regfile_sb #(.DATA_W(32), .DEPTH(16), .NRD(2), .SYNC_RD(0), .BYPASS(1), .ZERO_REG(0)) dut_a (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(o_rdata[0]), .rbusy(o_rbusy[0]), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_conflict(o_conf[0]), .busy_cnt(o_cnt[0]));

    regfile_sb #(.DATA_W(32), .DEPTH(16), .NRD(2), .SYNC_RD(0), .BYPASS(0), .ZERO_REG(1)) dut_b (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(o_rdata[1]), .rbusy(o_rbusy[1]), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_conflict(o_conf[1]), .busy_cnt(o_cnt[1]));

    regfile_sb #(.DATA_W(32), .DEPTH(16), .NRD(2), .SYNC_RD(1), .BYPASS(1), .ZERO_REG(0)) dut_c (
        .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
        .rdata(o_rdata[2]), .rbusy(o_rbusy[2]), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_conflict(o_conf[2]), .busy_cnt(o_cnt[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Value a read port should show right now, from the architectural rules.
    function automatic logic [31:0] exp_data(input int c, input int k);
        logic [3:0] a;
        a = raddr[k*4 +: 4];
        if (cfg_zr[c] != 0 && a == 4'd0) return 32'h0;
        if (cfg_byp[c] != 0 && wen && waddr == a && !(cfg_zr[c] != 0 && waddr == 4'd0)) return wdata;
        return m_mem[c][a];
    endfunction

    function automatic bit exp_busy(input int c, input int k);
        logic [3:0] a;
        a = raddr[k*4 +: 4];
        if (cfg_zr[c] != 0 && a == 4'd0) return 1'b0;
        return m_busy[c][a];
    endfunction

    function automatic logic [4:0] exp_cnt(input int c);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) n += int'(m_busy[c][i]);
        return 5'(n);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Compare every output of every instance against the model.
    task automatic check_all();
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rdata c%0d p%0d", c, k), o_rdata[c][k*32 +: 32],
                    (cfg_sync[c] != 0) ? m_rq[c][k] : exp_data(c, k));
                chk($sformatf("rbusy c%0d p%0d", c, k), 32'(o_rbusy[c][k]),
                    32'((cfg_sync[c] != 0) ? m_rqb[c][k] : exp_busy(c, k)));
            end
            chk($sformatf("rsv_conflict c%0d", c), 32'(o_conf[c]),
                32'(rsv_en && m_busy[c][rsv_addr]));
            chk($sformatf("busy_cnt c%0d", c), 32'(o_cnt[c]), 32'(exp_cnt(c)));
        end
    endtask

    // Apply the rising-edge rules to the model using the current inputs.
    task automatic model_edge();
        bit zw, zs, do_set;
        for (int c = 0; c < 3; c++) begin
            if (rst) begin
                for (int i = 0; i < 16; i++) begin
                    m_mem[c][i]  = 32'h0;
                    m_busy[c][i] = 1'b0;
                end
                for (int k = 0; k < 2; k++) begin
                    m_rq[c][k]  = 32'h0;
                    m_rqb[c][k] = 1'b0;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    m_rq[c][k]  = exp_data(c, k);
                    m_rqb[c][k] = exp_busy(c, k);
                end
                zw = (cfg_zr[c] != 0) && (waddr == 4'd0);
                zs = (cfg_zr[c] != 0) && (rsv_addr == 4'd0);
                do_set = rsv_en && !zs && (!m_busy[c][rsv_addr] || (wen && waddr == rsv_addr));
                if (wen && !zw) m_mem[c][waddr] = wdata;
                if (wen) m_busy[c][waddr] = 1'b0;
                if (do_set) m_busy[c][rsv_addr] = 1'b1;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        check_all();
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
        raddr = '0; rsv_en = 1'b0; rsv_addr = '0;
        @(posedge clk);
        #1;
        model_edge();

        // Reset state: every register reads zero, nothing busy.
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            raddr = {4'(15 - i), 4'(i)};
            settle();
            if (i == 15) chk("reset cnt", 32'(o_cnt[0]), 32'd0);
            tick();
        end

        // Same-cycle collision on R5, bypass vs. no bypass.
        wen = 1'b1; waddr = 4'd5; wdata = 32'hDEADBEEF; raddr = 8'h05;
        settle();
        chk("bypass same cycle", o_rdata[0][31:0], 32'hDEADBEEF);
        chk("no bypass old", o_rdata[1][31:0], 32'h0);
        tick();
        wen = 1'b0;
        settle();
        chk("no bypass next", o_rdata[1][31:0], 32'hDEADBEEF);
        tick();

        // Zero register: write and reserve of R0 are ignored.
        wen = 1'b1; waddr = 4'd0; wdata = 32'h1234; rsv_en = 1'b1; rsv_addr = 4'd0; raddr = 8'h00;
        settle();
        tick();
        wen = 1'b0; rsv_en = 1'b0;
        settle();
        chk("zero r0 data", o_rdata[1][31:0], 32'h0);
        chk("zero r0 cnt", 32'(o_cnt[1]), 32'd0);
        chk("normal r0 data", o_rdata[0][31:0], 32'h1234);
        tick();

        // Double reservation of R3, then retire it.
        rsv_en = 1'b1; rsv_addr = 4'd3; raddr = 8'h03;
        settle();
        chk("rsv first conflict", 32'(o_conf[1]), 32'd0);
        tick();
        settle();
        chk("rsv second conflict", 32'(o_conf[1]), 32'd1);
        chk("rsv cnt one", 32'(o_cnt[1]), 32'd1);
        tick();
        rsv_en = 1'b0; wen = 1'b1; waddr = 4'd3; wdata = 32'h77;
        settle();
        chk("r3 busy before wb", 32'(o_rbusy[1][0]), 32'd1);
        tick();
        wen = 1'b0;
        settle();
        chk("cnt after wb", 32'(o_cnt[1]), 32'd0);
        chk("r3 idle after wb", 32'(o_rbusy[1][0]), 32'd0);
        tick();

        // Write and reserve on the same register: set wins.
        rsv_en = 1'b1; rsv_addr = 4'd3;
        settle();
        tick();
        wen = 1'b1; waddr = 4'd3; wdata = 32'h88;
        settle();
        tick();
        wen = 1'b0; rsv_en = 1'b0;
        settle();
        chk("set wins cnt", 32'(o_cnt[1]), 32'd1);
        chk("set wins busy", 32'(o_rbusy[1][0]), 32'd1);
        tick();
        // Write R3 while reserving R7: net count change zero.
        wen = 1'b1; waddr = 4'd3; rsv_en = 1'b1; rsv_addr = 4'd7; raddr = 8'h73;
        settle();
        tick();
        wen = 1'b0; rsv_en = 1'b0;
        settle();
        chk("swap cnt", 32'(o_cnt[1]), 32'd1);
        chk("r7 busy", 32'(o_rbusy[1][1]), 32'd1);
        chk("r3 idle", 32'(o_rbusy[1][0]), 32'd0);
        tick();

        // Registered read latency, then reset with a concurrent write.
        wen = 1'b1; waddr = 4'd9; wdata = 32'hA5A5A5A5; raddr = 8'h20;
        settle();
        tick();
        wen = 1'b0; raddr = 8'h92;
        settle();
        chk("sync before", o_rdata[2][63:32], 32'h0);
        tick();
        settle();
        chk("sync after", o_rdata[2][63:32], 32'hA5A5A5A5);
        rst = 1'b1; wen = 1'b1; waddr = 4'd4; wdata = 32'h55; rsv_en = 1'b1; rsv_addr = 4'd6;
        tick();
        rst = 1'b0; wen = 1'b0; rsv_en = 1'b0;
        settle();
        chk("rst sync rdata", o_rdata[2][63:32], 32'h0);
        chk("rst cnt", 32'(o_cnt[0]), 32'd0);
        chk("rst r9 cleared", o_rdata[0][63:32], 32'h0);
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 59) == 0);
            wen      = 1'($urandom);
            waddr    = 4'($urandom);
            wdata    = $urandom;
            raddr    = 8'($urandom);
            rsv_en   = 1'($urandom);
            rsv_addr = 4'($urandom);
            settle();
            tick();
        end
        rst = 1'b0; wen = 1'b0; rsv_en = 1'b0;
        settle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
